// File: rtl/alu_lab_pkg.sv
// Shared definitions for the lab ALU: FSM state codes, opcode encoding and
// the nibble-increment helper used by operand entry.
package alu_lab_pkg;

   localparam int OP_W = 3;

   typedef enum logic [2:0] {
      ST_ENT_A  = 3'd0,
      ST_ENT_B  = 3'd1,
      ST_OP_SEL = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WAIT   = 3'd4,
      ST_SHOW   = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

   typedef enum logic [OP_W-1:0] {
      OP_AND = 3'd0,
      OP_OR  = 3'd1,
      OP_ADD = 3'd2,
      OP_SUB = 3'd3,
      OP_SLT = 3'd4,
      OP_XOR = 3'd5,
      OP_NOR = 3'd6,
      OP_SRL = 3'd7
   } alu_op_e;

   // Adds one to a single nibble; a wrap from F to 0 never carries outward.
   function automatic logic [31:0] nib_inc(input logic [31:0] v, input logic [2:0] idx);
      logic [31:0] r;
      logic [3:0]  n;
      r = v;
      n = v[{idx, 2'b00} +: 4];
      r[{idx, 2'b00} +: 4] = n + 4'd1;
      return r;
   endfunction

endpackage

// File: rtl/alu_entry_seq_if.sv
// Operand/opcode bus and start/done handshake between the entry sequencer
// (master) and the ALU datapath (slave).
interface alu_entry_seq_if
   import alu_lab_pkg::*;
#(
   parameter int OP_W = alu_lab_pkg::OP_W
);
   // Handshake: alu_start is high for exactly one cycle per operation, and A/B/op
   // are stable from then until the result is acknowledged. The ALU answers with
   // a one-cycle alu_done carrying alu_res in that same cycle; done is only
   // honoured while the sequencer is waiting, so early or stray pulses are lost.
   logic [31:0]     A;
   logic [31:0]     B;
   logic [OP_W-1:0] op;
   logic            alu_start;
   logic            alu_done;
   logic [31:0]     alu_res;

   modport master (output A, B, op, alu_start, input alu_done, alu_res);
   modport slave  (input A, B, op, alu_start, output alu_done, alu_res);

endinterface

// File: rtl/btn_edge.sv
// Two-flop synchronizer for an asynchronous button level followed by a
// registered rising-edge detector; one pulse per press however long it is held.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic pulse_q, pulse_d;

   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      pulse_d = sync2_q & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/alu_entry_seq.sv
// Cursor-driven operand/opcode entry and ALU start/done sequencing for the lab
// ALU, driven by three debounced push buttons.
module alu_entry_seq
   import alu_lab_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024,
   parameter int OP_W        = alu_lab_pkg::OP_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   btn_inc,
   input  logic                   btn_next,
   input  logic                   btn_clr,
   alu_entry_seq_if.master        alu,
   output logic [31:0]            result,
   output logic [2:0]             cursor,
   output logic [2:0]             state,
   output logic                   err
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic inc_p, next_p, clr_p;
   logic inc_e, next_e, clr_e;

   state_e          state_q,     state_d;
   logic [31:0]     a_q,         a_d;
   logic [31:0]     b_q,         b_d;
   logic [31:0]     result_q,    result_d;
   logic [OP_W-1:0] op_q,        op_d;
   logic [2:0]      cursor_q,    cursor_d;
   logic            err_q,       err_d;
   logic            alu_start_q, alu_start_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   btn_edge u_inc  (.clk(clk), .rst_n(rst_n), .din(btn_inc),  .pulse(inc_p));
   btn_edge u_next (.clk(clk), .rst_n(rst_n), .din(btn_next), .pulse(next_p));
   btn_edge u_clr  (.clk(clk), .rst_n(rst_n), .din(btn_clr),  .pulse(clr_p));

   // Coincident presses resolve clr > next > inc; the losers are discarded.
   always_comb begin
      clr_e  = clr_p;
      next_e = next_p & ~clr_p;
      inc_e  = inc_p & ~clr_p & ~next_p;
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      op_d        = op_q;
      cursor_d    = cursor_q;
      err_d       = err_q;
      alu_start_d = 1'b0;
      cnt_d       = cnt_q;

      case (state_q)
         ST_ENT_A, ST_ENT_B: begin
            if (clr_e) begin
               if (state_q == ST_ENT_A) a_d = '0;
               else                     b_d = '0;
               cursor_d = 3'd0;
            end else if (next_e) begin
               if (cursor_q == 3'd7) begin
                  cursor_d = 3'd0;
                  state_d  = (state_q == ST_ENT_A) ? ST_ENT_B : ST_OP_SEL;
               end else begin
                  cursor_d = cursor_q + 3'd1;
               end
            end else if (inc_e) begin
               if (state_q == ST_ENT_A) a_d = nib_inc(a_q, cursor_q);
               else                     b_d = nib_inc(b_q, cursor_q);
            end
         end
         ST_OP_SEL: begin
            if (clr_e) begin
               op_d = '0;
            end else if (next_e) begin
               state_d     = ST_EXEC;
               alu_start_d = 1'b1;
            end else if (inc_e) begin
               op_d = op_q + OP_W'(1);
            end
         end
         ST_EXEC: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            // A done arriving on the final count still counts as success.
            if (alu.alu_done) begin
               result_d = alu.alu_res;
               state_d  = ST_SHOW;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SHOW, ST_ERR: begin
            if (next_e) begin
               state_d  = ST_ENT_A;
               cursor_d = 3'd0;
               err_d    = 1'b0;
            end
         end
         default: state_d = ST_ENT_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ENT_A;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         op_q        <= '0;
         cursor_q    <= 3'd0;
         err_q       <= 1'b0;
         alu_start_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         op_q        <= op_d;
         cursor_q    <= cursor_d;
         err_q       <= err_d;
         alu_start_q <= alu_start_d;
         cnt_q       <= cnt_d;
      end
   end

   assign alu.A         = a_q;
   assign alu.B         = b_q;
   assign alu.op        = op_q;
   assign alu.alu_start = alu_start_q;
   assign result        = result_q;
   assign cursor        = cursor_q;
   assign state         = state_q;
   assign err           = err_q;

endmodule

// File: tb/tb_alu_entry_seq.sv
// Bench for alu_entry_seq: directed vector table, hand-written handshake and
// reset sequences, then random button traffic against a behavioural model.
module tb_alu_entry_seq;

  localparam int TMO = 16;
  localparam int S_ENT_A = 0, S_ENT_B = 1, S_OP_SEL = 2, S_EXEC = 3,
                 S_WAIT = 4, S_SHOW = 5, S_ERR = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_inc, btn_next, btn_clr;
  logic [31:0] result;
  logic [2:0] cursor, state;
  logic err;

  alu_entry_seq_if #(.OP_W(3)) alu_bus ();

  alu_entry_seq #(.TIMEOUT_CYC(TMO), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_inc(btn_inc), .btn_next(btn_next), .btn_clr(btn_clr),
    .alu(alu_bus),
    .result(result), .cursor(cursor), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model
  logic [31:0] m_a, m_b, m_res;
  int m_op, m_cur, m_st;
  logic m_err;

  typedef struct {
    logic inc;
    logic nxt;
    logic clr;
    int hold;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int exp_cur;
    int exp_st;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic i, input logic n, input logic c, input int h,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input int ec, input int es);
    vec_t v;
    v.inc = i; v.nxt = n; v.clr = c; v.hold = h;
    v.exp_a = ea; v.exp_b = eb; v.exp_cur = ec; v.exp_st = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bump(input logic [31:0] v, input int c);
    logic [31:0] nib, sh;
    sh = 32'(4 * c);
    nib = (v >> sh) % 16;
    return v - (nib << sh) + (((nib + 1) % 16) << sh);
  endfunction

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_cur = 0; m_st = S_ENT_A; m_err = 0;
  endfunction

  function automatic void model_press(input logic i, input logic n, input logic c);
    case (m_st)
      S_ENT_A, S_ENT_B: begin
        if (c) begin
          if (m_st == S_ENT_A) m_a = 0; else m_b = 0;
          m_cur = 0;
        end else if (n) begin
          if (m_cur == 7) begin m_cur = 0; m_st = m_st + 1; end
          else m_cur = m_cur + 1;
        end else if (i) begin
          if (m_st == S_ENT_A) m_a = bump(m_a, m_cur); else m_b = bump(m_b, m_cur);
        end
      end
      S_OP_SEL: begin
        if (c) m_op = 0;
        else if (n) m_st = S_EXEC;
        else if (i) m_op = (m_op + 1) % 8;
      end
      S_SHOW, S_ERR: begin
        if (!c && n) begin m_st = S_ENT_A; m_cur = 0; m_err = 0; end
      end
      default: ;
    endcase
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".A"}, alu_bus.A, m_a);
    chk({tag, ".B"}, alu_bus.B, m_b);
    chk({tag, ".op"}, 32'(alu_bus.op), 32'(m_op));
    chk({tag, ".cursor"}, 32'(cursor), 32'(m_cur));
    chk({tag, ".state"}, 32'(state), 32'(m_st));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".alu_start"}, 32'(alu_bus.alu_start), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".A"}, alu_bus.A, 32'd0);
    chk({tag, ".B"}, alu_bus.B, 32'd0);
    chk({tag, ".op"}, 32'(alu_bus.op), 32'd0);
    chk({tag, ".result"}, result, 32'd0);
    chk({tag, ".cursor"}, 32'(cursor), 32'd0);
    chk({tag, ".state"}, 32'(state), 32'd0);
    chk({tag, ".alu_start"}, 32'(alu_bus.alu_start), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    btn_inc = 0; btn_next = 0; btn_clr = 0; alu_bus.alu_done = 0;
    rst_n = 0;
    #1;
    check_reset("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
  endtask

  // Drive one press (buttons rise together), wait for it to take effect.
  task automatic press(input logic i, input logic n, input logic c, input int hold);
    @(negedge clk);
    btn_inc = i; btn_next = n; btn_clr = c;
    repeat (hold) @(negedge clk);
    btn_inc = 0; btn_next = 0; btn_clr = 0;
    repeat (3) @(negedge clk);
    model_press(i, n, c);
    check_model("press");
  endtask

  task automatic to_op_sel();
    for (int k = 0; k < 20 && m_st != S_OP_SEL; k++) press(1'b0, 1'b1, 1'b0, 1);
    chk("reach_op_sel", 32'(state), 32'(S_OP_SEL));
  endtask

  // Press next in OP_SEL and answer with done in WAIT cycle d (d >= TMO: never).
  task automatic do_exec(input int d, input logic [31:0] res);
    @(negedge clk);
    btn_next = 1;
    repeat (3) @(negedge clk);
    chk("pre_exec", {28'd0, alu_bus.alu_start, state}, {28'd0, 1'b0, 3'(S_OP_SEL)});
    @(negedge clk);
    chk("exec", {28'd0, alu_bus.alu_start, state}, {28'd0, 1'b1, 3'(S_EXEC)});
    @(negedge clk);
    btn_next = 0;
    for (int j = 0; j < TMO; j++) begin
      chk("wait", {28'd0, alu_bus.alu_start, state}, {28'd0, 1'b0, 3'(S_WAIT)});
      if (j == d) begin alu_bus.alu_done = 1; alu_bus.alu_res = res; end
      @(negedge clk);
      alu_bus.alu_done = 0;
      alu_bus.alu_res = $urandom;
      if (j == d) break;
    end
    if (d < TMO) begin m_res = res; m_st = S_SHOW; end
    else begin m_st = S_ERR; m_err = 1; end
    check_model("exec_end");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; btn_inc = 0; btn_next = 0; btn_clr = 0;
    alu_bus.alu_done = 0; alu_bus.alu_res = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1;
    @(negedge clk);

    // ---- directed vector table ----
    for (int i = 1; i <= 3; i++) tbl.push_back(mk(1, 0, 0, 2, 32'(i), 0, 0, S_ENT_A));
    tbl.push_back(mk(0, 1, 0, 2, 32'h3, 0, 1, S_ENT_A));
    for (int i = 1; i <= 16; i++)
      tbl.push_back(mk(1, 0, 0, 1, 32'(((i % 16) << 4) | 3), 0, 1, S_ENT_A));
    tbl.push_back(mk(1, 0, 0, 20, 32'h13, 0, 1, S_ENT_A));     // long hold = one step
    for (int i = 2; i <= 7; i++) tbl.push_back(mk(0, 1, 0, 2, 32'h13, 0, i, S_ENT_A));
    tbl.push_back(mk(0, 1, 0, 2, 32'h13, 0, 0, S_ENT_B));
    tbl.push_back(mk(1, 0, 0, 2, 32'h13, 32'h1, 0, S_ENT_B));
    tbl.push_back(mk(1, 0, 0, 2, 32'h13, 32'h2, 0, S_ENT_B));
    tbl.push_back(mk(0, 1, 1, 2, 32'h13, 32'h0, 0, S_ENT_B));   // clr beats next
    tbl.push_back(mk(1, 1, 0, 2, 32'h13, 32'h0, 1, S_ENT_B));   // next beats inc
    foreach (tbl[k]) begin
      press(tbl[k].inc, tbl[k].nxt, tbl[k].clr, tbl[k].hold);
      chk("tbl.A", alu_bus.A, tbl[k].exp_a);
      chk("tbl.B", alu_bus.B, tbl[k].exp_b);
      chk("tbl.cursor", 32'(cursor), 32'(tbl[k].exp_cur));
      chk("tbl.state", 32'(state), 32'(tbl[k].exp_st));
    end

    // ---- clr + inc together on a full operand ----
    reset_dut();
    for (int nib = 0; nib < 8; nib++) begin
      for (int c = 0; c < 8 - nib; c++) press(1'b1, 1'b0, 1'b0, 1);
      if (nib < 7) press(1'b0, 1'b1, 1'b0, 1);
    end
    chk("a_12345678", alu_bus.A, 32'h12345678);
    press(1'b1, 1'b0, 1'b1, 2);
    chk("clr_inc.A", alu_bus.A, 32'h0);
    chk("clr_inc.cursor", 32'(cursor), 32'd0);

    // ---- opcode select and successful handshake ----
    to_op_sel();
    press(1'b1, 1'b0, 1'b0, 1);
    press(1'b1, 1'b0, 1'b0, 1);
    chk("op_two", 32'(alu_bus.op), 32'd2);
    do_exec(5, 32'hDEADBEEF);
    chk("result_deadbeef", result, 32'hDEADBEEF);
    chk("state_show", 32'(state), 32'(S_SHOW));
    @(negedge clk);
    alu_bus.alu_done = 1; alu_bus.alu_res = 32'h11111111;   // stray done in SHOW
    @(negedge clk);
    alu_bus.alu_done = 0;
    @(negedge clk);
    chk("stray_done", result, 32'hDEADBEEF);
    press(1'b0, 1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 1'b0, 1);
    chk("rerun.A", alu_bus.A, 32'h1);

    // ---- timeout ----
    to_op_sel();
    do_exec(99, 32'h0);
    chk("tmo.state", 32'(state), 32'(S_ERR));
    chk("tmo.err", 32'(err), 32'd1);
    chk("tmo.result", result, 32'hDEADBEEF);
    press(1'b0, 1'b1, 1'b0, 1);
    chk("after_err.err", 32'(err), 32'd0);
    chk("after_err.op", 32'(alu_bus.op), 32'd2);
    chk("after_err.A", alu_bus.A, 32'h1);

    // ---- done on the final timeout cycle wins ----
    to_op_sel();
    do_exec(TMO - 1, 32'h0BADF00D);
    chk("last_cycle.state", 32'(state), 32'(S_SHOW));
    chk("last_cycle.result", result, 32'h0BADF00D);
    press(1'b0, 1'b1, 1'b0, 1);

    // ---- reset during WAIT ----
    to_op_sel();
    @(negedge clk);
    btn_next = 1;
    repeat (5) @(negedge clk);
    btn_next = 0;
    chk("rw.in_wait", 32'(state), 32'(S_WAIT));
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check_reset("rw.during");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    alu_bus.alu_done = 1; alu_bus.alu_res = 32'hCAFEF00D;
    @(negedge clk);
    alu_bus.alu_done = 0;
    repeat (2) @(negedge clk);
    check_reset("rw.after");
    model_reset();

    // ---- random traffic against the model ----
    for (int k = 0; k < 300; k++) begin
      logic i, n, c;
      i = 1'($urandom_range(0, 1));
      n = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 9) == 0);
      if (m_st == S_OP_SEL && n && !c) do_exec($urandom_range(0, 20), $urandom);
      else press(i, n, c, $urandom_range(1, 6));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
